// File: rtl/uarttx_arb_pkg.sv
// Shared types and helpers for the UART transmitter arbiter.
// Optional feature macro used by this block: UARTTX_ARB_LOCK_EN.
package uarttx_arb_pkg;

  // Largest supported requester count; the rotate helper works on this width.
  localparam int MAX_REQ   = 8;
  localparam int MAX_ID_W  = $clog2(MAX_REQ);

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } arb_state_t;

  // Rotate the low n bits of vec right by shift (bit 0 of the result is
  // vec[shift]); bits at and above n are returned as zero.
  function automatic logic [MAX_REQ-1:0] rotate_right(
    input logic [MAX_REQ-1:0] vec,
    input int                 shift,
    input int                 n
  );
    logic [MAX_REQ-1:0]  res;
    logic [MAX_ID_W-1:0] src;
    res = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        src    = MAX_ID_W'((i + shift) % n);
        res[i] = vec[src];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uarttx_arbiter_if.sv
// Requester and transmitter signal bundle for uarttx_arbiter.
// master: the arbiter side; slave: requesters plus transmitter side.
// UARTTX_ARB_LOCK_EN adds the req_lock vector.
interface uarttx_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_load;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
`ifdef UARTTX_ARB_LOCK_EN
  logic [NUM_REQ-1:0]   req_lock;

  modport master (
    input  req_valid, req_data, req_lock, tx_ready,
    output req_ready, tx_load, tx_data, grant_id, busy
  );
  modport slave (
    output req_valid, req_data, req_lock, tx_ready,
    input  req_ready, tx_load, tx_data, grant_id, busy
  );
`else
  modport master (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_load, tx_data, grant_id, busy
  );
  modport slave (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_load, tx_data, grant_id, busy
  );
`endif
endinterface

// File: rtl/uarttx_rr_pick.sv
// Combinational round-robin picker: searches last+1, last+2, ... modulo
// NUM_REQ and returns the first eligible requester.
module uarttx_rr_pick
  import uarttx_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [ID_W-1:0]    i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  int                 w_start;
  logic [MAX_REQ-1:0] w_rot;

  // Bit 0 of the rotated vector is the requester right after the last winner.
  assign w_start = (int'(i_last) + 1) % NUM_REQ;
  assign w_rot   = rotate_right(MAX_REQ'(i_elig), w_start, NUM_REQ);

  // Lowest set bit of the rotated vector wins; map it back to an index.
  always_comb begin
    o_any   = 1'b0;
    o_idx   = '0;
    o_grant = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        o_any = 1'b1;
        o_idx = ID_W'((w_start + j) % NUM_REQ);
      end
    end
    if (o_any) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uarttx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte requesters. Accepts one
// byte in IDLE, pulses tx_load for one cycle, then follows tx_ready low and
// high again before the next accept so a character is never double-loaded.
// Optional macro UARTTX_ARB_LOCK_EN: req_lock keeps the current owner as the
// only eligible requester so multi-byte messages stay together.
module uarttx_arbiter
  import uarttx_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic              clk,
  input logic              rst,
  uarttx_arbiter_if.master bus
);

  arb_state_t         r_state;
  arb_state_t         w_state_next;
  logic [7:0]         r_byte;
  logic [ID_W-1:0]    r_grant_id;
  logic [ID_W-1:0]    r_last;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_pick_grant;
  logic [ID_W-1:0]    w_pick_idx;
  logic               w_pick_any;
  logic               w_accept;
  logic               w_locked;
  logic [7:0]         w_req_byte [NUM_REQ];

  // Unpack the flat byte bus into one byte per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_byte
    assign w_req_byte[gi] = bus.req_data[8*gi +: 8];
  end

`ifdef UARTTX_ARB_LOCK_EN
  logic               r_lock_armed;
  logic [NUM_REQ-1:0] w_own_mask;

  assign w_own_mask = NUM_REQ'(1) << r_grant_id;
  assign w_locked   = (r_state == IDLE) && r_lock_armed && bus.req_lock[r_grant_id];
  assign w_elig     = w_locked ? (bus.req_valid & w_own_mask) : bus.req_valid;

  // Lock is armed by every accept and released by the first IDLE cycle in
  // which the owner's lock bit is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_armed <= 1'b0;
    end else if (w_accept) begin
      r_lock_armed <= 1'b1;
    end else if ((r_state == IDLE) && !bus.req_lock[r_grant_id]) begin
      r_lock_armed <= 1'b0;
    end
  end
`else
  assign w_locked = 1'b0;
  assign w_elig   = bus.req_valid;
`endif

  uarttx_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_elig  (w_elig),
    .i_last  (r_last),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // Next state and the combinational accept strobe; accept is held off during
  // reset so req_ready reads 0 while rst is high.
  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    bus.req_ready = '0;
    unique case (r_state)
      IDLE: begin
        if (!rst && bus.tx_ready && w_pick_any) begin
          w_accept      = 1'b1;
          bus.req_ready = w_pick_grant;
          w_state_next  = LOAD;
        end
      end
      LOAD:    w_state_next = WAIT_LO;
      WAIT_LO: if (!bus.tx_ready) w_state_next = WAIT_HI;
      WAIT_HI: if (bus.tx_ready)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register, byte latch, grant owner and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_byte     <= 8'h00;
      r_grant_id <= '0;
      r_last     <= ID_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_byte     <= w_req_byte[w_pick_idx];
        r_grant_id <= w_pick_idx;
        if (!w_locked) begin
          r_last <= w_pick_idx;
        end
      end
    end
  end

  assign bus.tx_load  = (r_state == LOAD);
  assign bus.tx_data  = r_byte;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uarttx_arbiter.sv
// Self-checking bench for uarttx_arbiter with NUM_REQ=3: a vector table for
// round-robin order, hand-written sequences for blocking, reset and lock,
// a transmitter model and a byte scoreboard checked on every tx_load.
`timescale 1ns/1ps
module tb_uarttx_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ID_W    = 2;
  localparam int NV      = 11;
  localparam int BUSY_LEN = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uarttx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus();

  uarttx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [ID_W-1:0] id;
    logic [7:0]      data;
  } exp_t;

  typedef struct {
    logic                   do_rst;
    int                     lag;
    logic [NUM_REQ-1:0]     valid;
    logic [8*NUM_REQ-1:0]   data;
    int                     exp_id;
  } vec_t;

  exp_t sb_q[$];
  vec_t tv [NV];

  int n_checks = 0;
  int n_pass   = 0;
  int n_pushed = 0;
  int load_cnt = 0;
  int cyc      = 0;
  int last_load_cyc = -100;
  logic acc_prev  = 1'b0;
  logic load_seen = 1'b0;

  // transmitter model controls
  logic xm_force_low = 1'b0;
  int   lag_cfg = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail_msg(input string nm);
    n_checks++;
    $display("FAIL %s", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input int id, input logic [7:0] b);
    exp_t e;
    e.id   = ID_W'(id);
    e.data = b;
    sb_q.push_back(e);
    n_pushed++;
  endtask

  task automatic wait_accept(input int exp_id, input string nm);
    int n;
    logic [NUM_REQ-1:0] exp_oh;
    exp_oh = '0;
    exp_oh[exp_id] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.req_ready == '0) && (n < 300));
    if (bus.req_ready == '0) fail_msg({nm, " accept timeout"});
    else check(nm, 32'(bus.req_ready), 32'(exp_oh));
  endtask

  task automatic wait_load(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_load && (n < 20));
    if (!bus.tx_load) fail_msg({nm, " load timeout"});
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    bus.req_valid = '1;
    step();
    step();
    check("rst_busy",     32'(bus.busy),      32'd0);
    check("rst_tx_load",  32'(bus.tx_load),   32'd0);
    check("rst_tx_data",  32'(bus.tx_data),   32'h00);
    check("rst_grant_id", 32'(bus.grant_id),  32'd0);
    check("rst_req_rdy",  32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each tx_load.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      load_seen = bus.tx_load;
      if (!rst) begin
        check("rdy_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
        check("rdy_idle_only", 32'(bus.busy && (bus.req_ready != '0)), 32'd0);
        if (bus.tx_load) begin
          load_cnt++;
          check("load_latency", 32'(acc_prev), 32'd1);
          check("load_spacing", 32'((cyc - last_load_cyc) >= 4), 32'd1);
          last_load_cyc = cyc;
          if (sb_q.size() == 0) begin
            fail_msg("unexpected tx_load");
          end else begin
            e = sb_q.pop_front();
            $display("load: tx_data=%02h grant_id=%0d (expected %02h/%0d)",
                     bus.tx_data, bus.grant_id, e.data, e.id);
            check("tx_data",  32'(bus.tx_data),  32'(e.data));
            check("grant_id", 32'(bus.grant_id), 32'(e.id));
          end
        end
        acc_prev = |(bus.req_ready & bus.req_valid);
      end else begin
        acc_prev = 1'b0;
      end
    end
  end

  // Transmitter model: after a load, optional lag, then busy for BUSY_LEN.
  initial begin
    int   lag_left;
    int   busy_left;
    logic pending;
    lag_left  = 0;
    busy_left = 0;
    pending   = 1'b0;
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (xm_force_low) begin
        bus.tx_ready = 1'b0;
        pending = 1'b0;
      end else begin
        if (load_seen) begin
          check("no_double_load", 32'(pending), 32'd0);
          pending   = 1'b1;
          lag_left  = lag_cfg;
          busy_left = BUSY_LEN;
        end
        if (pending) begin
          if (lag_left > 0) begin
            lag_left--;
          end else begin
            bus.tx_ready = 1'b0;
            if (busy_left > 0) busy_left--;
            else begin
              bus.tx_ready = 1'b1;
              pending = 1'b0;
            end
          end
        end else begin
          bus.tx_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int n;
    int loads_before;
    logic [8*NUM_REQ-1:0] d;

    tv[0]  = '{1'b1, 0, 3'b111, 24'hA2A1A0, 0};
    tv[1]  = '{1'b0, 0, 3'b111, 24'hB2B1B0, 1};
    tv[2]  = '{1'b0, 0, 3'b111, 24'hC2C1C0, 2};
    tv[3]  = '{1'b0, 1, 3'b111, 24'hD2D1D0, 0};
    tv[4]  = '{1'b0, 1, 3'b111, 24'hE2E1E0, 1};
    tv[5]  = '{1'b0, 0, 3'b111, 24'hF2F1F0, 2};
    tv[6]  = '{1'b0, 0, 3'b101, 24'h121110, 0};
    tv[7]  = '{1'b0, 0, 3'b101, 24'h222120, 2};
    tv[8]  = '{1'b0, 0, 3'b010, 24'h323130, 1};
    tv[9]  = '{1'b0, 1, 3'b100, 24'h424140, 2};
    tv[10] = '{1'b0, 0, 3'b011, 24'h525150, 0};

    bus.req_valid = '0;
    bus.req_data  = '0;
`ifdef UARTTX_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif

    do_reset();

    // Single byte from requester 0.
    loads_before = load_cnt;
    bus.req_valid = 3'b001;
    bus.req_data  = 24'hEEEE41;
    expect_byte(0, 8'h41);
    wait_accept(0, "single_grant");
    wait_load("single");
    check("single_rdy_pulse", 32'(bus.req_ready), 32'd0);
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 30; i++) step();
    check("single_load_count", 32'(load_cnt - loads_before), 32'd1);

    // Table: fairness, partial masks, ready lag.
    for (k = 0; k < NV; k++) begin
      if (tv[k].do_rst) do_reset();
      lag_cfg = tv[k].lag;
      bus.req_valid = tv[k].valid;
      bus.req_data  = tv[k].data;
      d = tv[k].data;
      expect_byte(tv[k].exp_id, d[8*tv[k].exp_id +: 8]);
      wait_accept(tv[k].exp_id, $sformatf("tv_grant[%0d]", k));
      wait_load($sformatf("tv[%0d]", k));
      step();
    end
    bus.req_valid = '0;
    lag_cfg = 0;

    // Blocked transmitter: nothing accepted while tx_ready=0.
    do_reset();
    xm_force_low = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tx_ready && (n < 10));
    step();
    bus.req_valid = 3'b011;
    bus.req_data  = 24'h00B1B0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("blocked_req_ready", 32'(bus.req_ready), 32'd0);
      check("blocked_tx_load",   32'(bus.tx_load),   32'd0);
    end
    expect_byte(0, 8'hB0);
    step();
    xm_force_low = 1'b0;
    wait_accept(0, "blocked_grant");
    wait_load("blocked");
    step();
    bus.req_valid = '0;

    // Reset in WAIT_HI.
    bus.req_valid = 3'b001;
    bus.req_data  = 24'h000055;
    expect_byte(0, 8'h55);
    wait_accept(0, "mid_grant");
    wait_load("mid");
    step();
    bus.req_valid = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tx_ready && (n < 10));
    step();
    step();
    check("mid_busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_busy",    32'(bus.busy),     32'd0);
    check("mid_rst_tx_data", 32'(bus.tx_data),  32'h00);
    check("mid_rst_grant",   32'(bus.grant_id), 32'd0);
    check("mid_rst_tx_load", 32'(bus.tx_load),  32'd0);
    rst = 1'b0;
    bus.req_valid = 3'b011;
    bus.req_data  = 24'h006665;
    expect_byte(0, 8'h65);
    wait_accept(0, "post_rst_grant");
    wait_load("post_rst");
    step();
    bus.req_valid = '0;

`ifdef UARTTX_ARB_LOCK_EN
    // Locked requester 1 sends two bytes back to back ahead of requester 0.
    bus.req_valid = 3'b011;
    bus.req_lock  = 3'b010;
    bus.req_data  = 24'h004830;
    expect_byte(1, 8'h48);
    wait_accept(1, "lock_grant_1st");
    wait_load("lock_1st");
    step();
    bus.req_data  = 24'h004930;
    expect_byte(1, 8'h49);
    wait_accept(1, "lock_grant_2nd");
    wait_load("lock_2nd");
    step();
    bus.req_lock  = 3'b000;
    bus.req_valid = 3'b001;
    expect_byte(0, 8'h30);
    wait_accept(0, "lock_release_grant");
    wait_load("lock_release");
    step();
    bus.req_valid = '0;
`endif

    // Drain and confirm every expected byte was loaded exactly once.
    n = 0;
    do begin
      step();
      n++;
    end while ((bus.busy || !bus.tx_ready) && (n < 100));
    check("drain_idle", 32'(bus.busy), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("total_loads", 32'(load_cnt), 32'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uarttx_arbiter.md
# uarttx_arbiter

Shares one UART transmitter between NUM_REQ byte-producing requesters (e.g. PDP-8 teleprinter output and the debug console). Requesters present bytes on a valid/ready handshake; the arbiter picks one round-robin, issues a one-cycle tx_load with the byte, then tracks tx_ready through the character so it never double-loads. It sits between the requesters and the transmitter's tx_load/tx_data/tx_ready port.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- ID_W, $clog2(NUM_REQ): width of grant_id.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte.
- req_data  in  NUM_REQ×8  packed byte per requester; byte i at [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept strobe; byte i taken when req_valid[i] && req_ready[i].
- tx_load  out  1  one-cycle load strobe to the transmitter.
- tx_data  out  8  byte to the transmitter; valid while tx_load=1.
- tx_ready  in  1  transmitter idle and able to accept a load.
- grant_id  out  ID_W  index of the requester owning the current or last character.
- busy  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, LOAD, WAIT_LO, WAIT_HI.
- IDLE: if tx_ready=1 and any eligible req_valid:
  - pick the winner;
  - assert req_ready[winner] combinationally this cycle;
  - latch req_data[winner] into the byte register and the winner into grant_id;
  - go to LOAD.
  - Otherwise stay, req_ready=0.
- LOAD: tx_load=1, tx_data=latched byte, for exactly one cycle; go to WAIT_LO.
- WAIT_LO: wait for tx_ready=0, then go to WAIT_HI. Covers a transmitter that drops ready 0 or 1 cycles after sampling tx_load.
- WAIT_HI: wait for tx_ready=1, then go to IDLE.
- Round-robin:
  - pointer last holds the previous winner;
  - search order is last+1, last+2, … modulo NUM_REQ;
  - last updates only on accept.
- req_ready never asserts outside IDLE, and at most one bit is high.
- tx_data holds the last loaded byte between loads. It does not return to 0.

## Timing
- Reset values: state=IDLE, tx_load=0, tx_data=8'h00, req_ready=0, grant_id=0, busy=0, last=NUM_REQ-1, so requester 0 has first priority.
- Accept-to-load latency: 1 cycle. tx_load is high in the cycle after the req_ready pulse.
- Minimum spacing between tx_load pulses: 4 cycles (LOAD, WAIT_LO, WAIT_HI, IDLE accept) plus the transmitter's busy time.
- tx_ready=1 in WAIT_LO is treated as "not yet dropped". The arbiter stays there; there is no timeout.
- tx_ready=0 in IDLE blocks all accepts; pending requests wait without loss.
- A requester dropping req_valid before acceptance is legal. Arbitration re-evaluates every IDLE cycle.
- All requesters valid simultaneously: grants rotate strictly, e.g. 0,1,2,0… for NUM_REQ=3.
- rst asserted in any state forces reset values on the next edge. A character already in the transmitter is not recalled. No partial tx_load pulse is emitted.

## Configuration
- UARTTX_ARB_LOCK_EN defined:
  - adds input port req_lock (NUM_REQ).
  - If req_lock[grant_id]=1 on returning to IDLE, only grant_id is eligible. The arbiter waits for it even if others are valid.
  - Eligibility is released in the first IDLE cycle where req_lock[grant_id]=0.
  - last is unchanged while locked.
  - Lock lets multi-byte messages go out uninterleaved.
- UARTTX_ARB_LOCK_EN undefined: the port is absent and arbitration is pure round-robin.

## Structure
- Package uarttx_arb_pkg:
  - state enum type (IDLE, LOAD, WAIT_LO, WAIT_HI);
  - MAX_REQ=8 constant;
  - rotate-priority helper function.
- One sub-module, uarttx_rr_pick:
  - inputs: eligible request vector and last pointer;
  - outputs: combinational one-hot grant, grant index, and any-grant flag.
- The FSM, byte register and lock logic live in uarttx_arbiter.

## Test plan
- Single byte: NUM_REQ=2, tx_ready=1, req_valid=01, byte 8'h41. Expect req_ready=01 for 1 cycle, tx_load with tx_data=8'h41 the next cycle, exactly one load.
- Fairness: NUM_REQ=3, all valid continuously, model transmitter busy 10 cycles per byte. Expect grant_id sequence 0,1,2,0,1,2 and each byte loaded once.
- Ready lag: the transmitter drops tx_ready 1 cycle late after tx_load. Expect no second tx_load until tx_ready goes low and then high again.
- Blocked transmitter: tx_ready=0 for 20 cycles with req_valid=11. Expect req_ready=0 and tx_load=0 throughout; the grant goes to requester 0 on the first tx_ready=1 cycle.
- Reset mid-character: assert rst in WAIT_HI. Expect busy=0, tx_data=8'h00, and the next grant to requester 0 with last reset.
- Lock (UARTTX_ARB_LOCK_EN): requester 1 locked sends 8'h48, 8'h49 while requester 0 is valid. Expect both requester-1 bytes consecutively, then requester 0's byte after the lock drops.
